// File: rtl/spm_serial_mult.sv
// spm_serial_mult: serial-parallel multiplier built from a chain of WIDTH
// carry-save cells. The multiplicand is captured in parallel. The multiplier
// is shifted in LSB first. The product leaves serially (p_bit/p_valid) and
// is also presented in parallel (product) together with a one-cycle done.
//
// Build option: define SPM_SIGNED_EN for two's-complement operands.
// Without it, operands are unsigned.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   start    in   request, accepted only from the idle state
//   x        in   WIDTH   multiplicand, captured on the accepting edge
//   y        in   WIDTH   multiplier, captured on the accepting edge
//   busy     out  multiplication in progress
//   p_bit    out  serial product bit, LSB first
//   p_valid  out  qualifies p_bit
//   product  out  2*WIDTH parallel product, held until the next result
//   done     out  one-cycle pulse when product is valid
module spm_serial_mult #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 p_bit,
    output logic                 p_valid,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(2 * WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_p_valid_nxt;
    logic               w_p_bit_nxt;

    logic [WIDTH-1:0]   r_xr;
    logic [WIDTH-1:0]   r_yr;
    logic [WIDTH-1:0]   r_s;
    logic [WIDTH-1:0]   r_c;
    logic [PW-1:0]      r_psr;
    logic [CNT_W-1:0]   r_cnt;

    logic               r_busy;
    logic               r_p_bit;
    logic               r_p_valid;
    logic               r_done;
    logic [PW-1:0]      r_product;

    logic               w_ybit;
    logic               w_y_fill;
    logic               w_top_in;
    logic [WIDTH-1:0]   w_pp;
    logic [WIDTH-1:0]   w_sin;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_cry;

    // Carry-save cell chain. Cell i adds its partial product, its own
    // carry, and the sum of cell i+1. The whole array therefore shifts
    // right by one weight every cycle.
    always_comb begin
        w_ybit   = r_yr[0];
        w_pp     = r_xr & {WIDTH{w_ybit}};
        w_top_in = 1'b0;
        w_y_fill = 1'b0;
`ifdef SPM_SIGNED_EN
        // The MSB of x carries negative weight. -t*2^(W-1) is rewritten as
        // (1-t)*2^(W-1) - 2^(W-1). Summed over all 2W cycles, the constant
        // term is +2^(W-1) mod 2^(2W). That term is injected once into the
        // top cell in the first cycle.
        w_pp[WIDTH-1] = ~(r_xr[WIDTH-1] & w_ybit);
        w_top_in      = (r_cnt == '0);
        w_y_fill      = r_yr[WIDTH-1];
`endif
        w_sin = {w_top_in, r_s[WIDTH-1:1]};
        w_sum = w_pp ^ r_c ^ w_sin;
        w_cry = (w_pp & r_c) | (w_pp & w_sin) | (r_c & w_sin);
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_accept    = 1'b1;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // The outputs trail the internal state by one cycle. busy rises
        // straight away, and it stays up through the cycle that shows done.
        w_busy_nxt    = (w_state_nxt != S_IDLE) || (r_state == S_DONE);
        w_done_nxt    = (r_state == S_DONE);
        w_p_valid_nxt = (r_state == S_RUN);
        w_p_bit_nxt   = (r_state == S_RUN) ? w_sum[0] : 1'b0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, cell state, product shift register and counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xr  <= '0;
            r_yr  <= '0;
            r_s   <= '0;
            r_c   <= '0;
            r_psr <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_xr  <= x;
            r_yr  <= y;
            r_s   <= '0;
            r_c   <= '0;
            r_psr <= '0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_s   <= w_sum;
            r_c   <= w_cry;
            r_yr  <= {w_y_fill, r_yr[WIDTH-1:1]};
            r_psr <= {w_sum[0], r_psr[PW-1:1]};
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy    <= 1'b0;
            r_p_bit   <= 1'b0;
            r_p_valid <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_p_bit   <= w_p_bit_nxt;
            r_p_valid <= w_p_valid_nxt;
            r_done    <= w_done_nxt;
            if (r_state == S_DONE) begin
                r_product <= r_psr;
            end
        end
    end

    assign busy    = r_busy;
    assign p_bit   = r_p_bit;
    assign p_valid = r_p_valid;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_spm_serial_mult.sv
module tb_spm_serial_mult;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        busy;
    logic        p_bit;
    logic        p_valid;
    logic [15:0] product;
    logic        done;

    logic        start16;
    logic [15:0] x16;
    logic [15:0] y16;
    logic        busy16;
    logic        p_bit16;
    logic        p_valid16;
    logic [31:0] product16;
    logic        done16;

    int checks;
    int failures;

    logic [15:0] exp_q[$];

`ifdef SPM_SIGNED_EN
    localparam logic [15:0] E_FFFF = 16'h0001;
    localparam logic [15:0] E_FF02 = 16'hFFFE;
`else
    localparam logic [15:0] E_FFFF = 16'hFE01;
    localparam logic [15:0] E_FF02 = 16'h01FE;
`endif

    spm_serial_mult #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .busy(busy), .p_bit(p_bit), .p_valid(p_valid),
        .product(product), .done(done)
    );

    spm_serial_mult #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .x(x16), .y(y16),
        .busy(busy16), .p_bit(p_bit16), .p_valid(p_valid16),
        .product(product16), .done(done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] ea;
        logic [15:0] eb;
`ifdef SPM_SIGNED_EN
        ea = {{8{a[7]}}, a};
        eb = {{8{b[7]}}, b};
`else
        ea = {8'd0, a};
        eb = {8'd0, b};
`endif
        return 16'(ea * eb);
    endfunction

    function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] ea;
        logic [31:0] eb;
`ifdef SPM_SIGNED_EN
        ea = {{16{a[15]}}, a};
        eb = {{16{b[15]}}, b};
`else
        ea = {16'd0, a};
        eb = {16'd0, b};
`endif
        return 32'(ea * eb);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one 8-bit multiply, push its expectation, and wait a bounded
    // time for done.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] want, input string tag);
        int n;
        exp_q.push_back(model8(a, b));
        start = 1'b1;
        x     = a;
        y     = b;
        tick();
        start = 1'b0;
        n = 0;
        while (n < 40 && !done) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_latency"}, 64'(n), 64'd17);
        check({tag, "_product"}, 64'(product), 64'(want));
        tick();
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    // Scoreboard: rebuild the serial stream and compare at each done pulse.
    initial begin
        logic [15:0] stream;
        int          nbits;
        logic [15:0] e;
        stream = '0;
        nbits  = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stream = '0;
                nbits  = 0;
            end else begin
                if (p_valid) begin
                    stream = {p_bit, stream[15:1]};
                    nbits++;
                end
                if (done) begin
                    check("sb_expected_present", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("sb_product", 64'(product), 64'(e));
                        check("sb_serial", 64'(stream), 64'(e));
                        check("sb_nbits", 64'(nbits), 64'd16);
                    end
                    stream = '0;
                    nbits  = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] e1;
        int          ndone;
        int          busy_low;
        int          done_at[3];
        int          nvalid;
        int          done16_at;
        logic [31:0] prod16_seen;

        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        start    = 1'b0;
        x        = '0;
        y        = '0;
        start16  = 1'b0;
        x16      = '0;
        y16      = '0;

        // Reset state
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_p_valid", 64'(p_valid), 64'd0);
        check("rst_p_bit", 64'(p_bit), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", 64'(product), 64'd0);
        check("rst_product16", 64'(product16), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // 3 x 5: cycle-exact serial stream and done timing
        e1 = model8(8'd3, 8'd5);
        exp_q.push_back(e1);
        start = 1'b1;
        x     = 8'd3;
        y     = 8'd5;
        tick();
        start = 1'b0;
        x     = 8'hC3;
        y     = 8'h3C;
        check("t1_busy_rise", 64'(busy), 64'd1);
        check("t1_no_valid_yet", 64'(p_valid), 64'd0);
        for (int i = 0; i < 16; i++) begin
            tick();
            check("t1_p_valid", 64'(p_valid), 64'd1);
            check("t1_p_bit", 64'(p_bit), 64'(e1[i]));
            check("t1_no_early_done", 64'(done), 64'd0);
        end
        tick();
        check("t1_done", 64'(done), 64'd1);
        check("t1_product", 64'(product), 64'h000F);
        check("t1_valid_off", 64'(p_valid), 64'd0);
        check("t1_busy_in_done", 64'(busy), 64'd1);
        tick();
        check("t1_done_pulse", 64'(done), 64'd0);
        check("t1_busy_fall", 64'(busy), 64'd0);
        check("t1_product_held", 64'(product), 64'h000F);

        // Corner operands
        run8(8'hFF, 8'hFF, E_FFFF, "ffxff");
        run8(8'hFF, 8'h02, E_FF02, "ffx02");
        run8(8'h80, 8'h80, 16'h4000, "80x80");

        // start held high: back-to-back results, operands disturbed mid-RUN
        start    = 1'b1;
        x        = 8'd7;
        y        = 8'd9;
        ndone    = 0;
        busy_low = 0;
        for (int k = 0; k < 54; k++) begin
            if (k % 18 == 0) exp_q.push_back(model8(8'd7, 8'd9));
            if (k % 18 == 3) begin
                x = 8'hAA;
                y = 8'h55;
            end
            if (k % 18 == 10) begin
                x = 8'd7;
                y = 8'd9;
            end
            tick();
            if (done) begin
                if (ndone < 3) done_at[ndone] = k;
                ndone++;
            end
            if (!busy) busy_low++;
        end
        start = 1'b0;
        check("b2b_ndone", 64'(ndone), 64'd3);
        check("b2b_done0", 64'(done_at[0]), 64'd17);
        check("b2b_done1", 64'(done_at[1]), 64'd35);
        check("b2b_done2", 64'(done_at[2]), 64'd53);
        check("b2b_busy_held", 64'(busy_low), 64'd0);
        check("b2b_product", 64'(product), 64'd63);
        tick();
        check("b2b_busy_fall", 64'(busy), 64'd0);

        // Reset mid-RUN, then a fresh multiply
        start = 1'b1;
        x     = 8'd5;
        y     = 8'd6;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("mid_busy_before", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_p_valid", 64'(p_valid), 64'd0);
        check("mid_rst_p_bit", 64'(p_bit), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_product", 64'(product), 64'd0);
        tick();
        tick();
        rst   = 1'b1;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done) ndone++;
        end
        check("mid_no_done", 64'(ndone), 64'd0);
        check("mid_idle", 64'(busy), 64'd0);
        run8(8'd2, 8'd4, 16'd8, "after_rst");

        // WIDTH=16: zero multiplicand, all-ones multiplier
        start16 = 1'b1;
        x16     = 16'h0000;
        y16     = 16'hFFFF;
        tick();
        start16     = 1'b0;
        nvalid      = 0;
        ndone       = 0;
        done16_at   = -1;
        prod16_seen = 32'hDEAD_BEEF;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (p_valid16) nvalid++;
            if (done16) begin
                ndone++;
                done16_at   = k;
                prod16_seen = product16;
            end
        end
        check("w16_nvalid", 64'(nvalid), 64'd32);
        check("w16_ndone", 64'(ndone), 64'd1);
        check("w16_done_at", 64'(done16_at), 64'd32);
        check("w16_product", 64'(prod16_seen), 64'(model16(16'h0000, 16'hFFFF)));
        check("w16_busy_fall", 64'(busy16), 64'd0);

        tick();
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spm_serial_mult.md
# spm_serial_mult

Parametrised serial-parallel multiplier built from a chain of WIDTH carry-save cells, each holding its own sum/carry state. It is the generalised successor of the fixed spm datapath. It adds a start/busy/done handshake, parallel operand capture, and both serial and parallel product output. It sits between operand producers and the accumulator datapath, and is the target of per-cell gold/gate equivalence partitions.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal range 2..64.
- CNT_W, $clog2(2*WIDTH)+1, cycle-counter width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; rst=0 forces the reset state immediately.
- start  in  1  request; accepted only when busy=0.
- x  in  WIDTH  parallel multiplicand; captured on the accepting edge.
- y  in  WIDTH  multiplier; captured on the accepting edge, then shifted out LSB first.
- busy  out  1  high while a multiplication is in progress.
- p_bit  out  1  serial product bit, LSB first.
- p_valid  out  1  qualifies p_bit.
- product  out  2*WIDTH  parallel product; held stable until the next accepted start.
- done  out  1  one-cycle pulse when product becomes valid.

## Operation
- Three states: IDLE, RUN, DONE.
- IDLE → RUN when start=1: latch x into xr and y into the y shift register, clear all cell sum/carry bits, counter=0.
- RUN, each cycle:
  - Feed the y shift register LSB (the sign bit once exhausted, see Configuration) into all cells.
  - Cell i computes the full-adder sum of xr[i]&ybit, its own carry, and cell i+1's sum.
  - Cell 0's sum is p_bit; it is also shifted into the MSB of the product shift register.
  - Counter increments.
- RUN → DONE when counter reaches 2*WIDTH-1.
- DONE → IDLE unconditionally after one cycle. done=1 only in DONE.
- start is ignored while busy=1; no queueing.
- busy=1 in RUN and DONE. start asserted during DONE is not accepted; the earliest accepting edge is the one ending the first IDLE cycle.
- Arithmetic:
  - Unsigned: product = x*y, full 2*WIDTH bits, no truncation or overflow.
  - Carries beyond bit 2*WIDTH-1 are discarded; they are provably zero for the configured mode.
- Reset (rst=0 at any time, including mid-RUN):
  - state=IDLE; busy=0, p_bit=0, p_valid=0, done=0, product=0.
  - All cell sum/carry state cleared.
  - An interrupted operation is abandoned and never produces done.

## Timing
- Accepting edge E0 (start=1, busy=0): busy=1 in the cycle following E0.
- Product bit i (i=0..2*WIDTH-1) is on p_bit, with p_valid=1, in the cycle following edge E0+i+1.
- p_valid=0 outside those 2*WIDTH cycles.
- done=1 and product valid in the cycle following edge E0+2*WIDTH+1.
- busy falls on edge E0+2*WIDTH+2. Earliest next accept is edge E0+2*WIDTH+2 if start is high in that IDLE cycle.
- Total: 2*WIDTH+2 cycles from accept to re-ready.
- x and y may change freely after E0; no combinational path from any input to any output.

## Configuration
- SPM_SIGNED_EN defined:
  - x and y are two's-complement.
  - After WIDTH cycles the y stream repeats y[WIDTH-1] (sign extension).
  - The top cell forms its partial product with a two's-complement-corrected term, so that product = signed(x)*signed(y) in 2*WIDTH bits.
  - -2^(WIDTH-1) * -2^(WIDTH-1) is representable and must be exact.
- SPM_SIGNED_EN undefined:
  - Unsigned operation; the y stream feeds zeros after WIDTH cycles.
  - Top cell identical to the others.

## Test plan
- WIDTH=8, unsigned: x=3, y=5, start one cycle → p_bit stream 1,1,1,1,0… (LSB first), product=16'h000F, done one pulse 18 cycles after the accepting edge.
- WIDTH=8, unsigned: x=8'hFF, y=8'hFF → product=16'hFE01. Same operands with SPM_SIGNED_EN → 16'h0001.
- WIDTH=8: x=8'hFF, y=8'h02 → 16'h01FE unsigned; 16'hFFFE with SPM_SIGNED_EN. With SPM_SIGNED_EN, x=y=8'h80 → 16'h4000.
- start held high continuously with x=7, y=9 → back-to-back results of 63, done every 18 cycles, start ignored while busy=1; x/y changed mid-RUN do not affect the result.
- rst pulled low at counter=5 mid-RUN, then released → all outputs 0 immediately, no done pulse; next start with x=2, y=4 yields 8.
- WIDTH=16: x=0, y=16'hFFFF → product=0, p_valid high exactly 32 cycles.
